cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter.sv | 168 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: six single-entry result buffers drained one per cycle
// onto a registered broadcast bus, using round-robin or fixed-priority selection.
module cdb_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ADD1_valid,
  input  logic        ADD2_valid,
  input  logic        ADD3_valid,
  input  logic        MULT1_valid,
  input  logic        MULT2_valid,
  input  logic [31:0] ADD1_result,
  input  logic [31:0] ADD2_result,
  input  logic [31:0] ADD3_result,
  input  logic [31:0] MULT1_result,
  input  logic [31:0] MULT2_result,
  output logic        ADD1_ready,
  output logic        ADD2_ready,
  output logic        ADD3_ready,
  output logic        MULT1_ready,
  output logic        MULT2_ready,
  input  logic        LS_valid,
  input  logic [31:0] LS_value,
  input  logic [2:0]  LS_idx,
  output logic        LS_ready,
  output logic        cdb_valid,
  output logic [3:0]  cdb_tag,
  output logic [31:0] cdb_data,
  output logic        err_bad_idx
);

  localparam int DATA_W = 32;
  localparam int NSRC   = 6;
  localparam logic [2:0] LS_SLOT = 3'd5;

  // Source slots: 0..4 = ADD1, ADD2, ADD3, MULT1, MULT2; 5 = LS.
  logic [NSRC-1:0]   src_valid;
  logic [NSRC-1:0]   src_ready;
  logic [DATA_W-1:0] src_data [NSRC];

  logic [NSRC-1:0]   full_p0;
  logic [DATA_W-1:0] buf_p0 [NSRC];
  logic [3:0]        ls_tag_p0;
  logic [2:0]        last_p0;

  logic [NSRC-1:0]   gnt;
  logic              gnt_any;
  logic [2:0]        gnt_idx;
  logic [2:0]        cand;
  logic [3:0]        gnt_tag;
  logic [NSRC-1:0]   fire;
  logic [NSRC-1:0]   fill;
  logic              ls_bad;

  logic              vld_p1;
  logic [3:0]        tag_p1;
  logic [DATA_W-1:0] data_p1;
  logic              err_bad;

  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input logic [3:0] step);
    logic [3:0] sum;
    sum = {1'b0, base} + step;
    if (sum >= 4'd6) sum = sum - 4'd6;
    return sum[2:0];
  endfunction

  assign src_valid = {LS_valid, MULT2_valid, MULT1_valid, ADD3_valid, ADD2_valid, ADD1_valid};

  assign src_data[0] = ADD1_result;
  assign src_data[1] = ADD2_result;
  assign src_data[2] = ADD3_result;
  assign src_data[3] = MULT1_result;
  assign src_data[4] = MULT2_result;
  assign src_data[5] = LS_value;

  // Grant selection over the buffers that are currently full.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 3'd0;
    cand    = 3'd0;
    if (RR_EN != 0) begin
      for (int k = 1; k <= NSRC; k++) begin
        cand = wrap_idx(last_p0, 4'(k));
        if (!gnt_any && full_p0[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (!gnt_any && full_p0[i]) begin
          gnt_any = 1'b1;
          gnt_idx = 3'(i);
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt_tag = 4'd0;
    if (gnt_any) begin
      if (gnt_idx == LS_SLOT) gnt_tag = ls_tag_p0;
      else                    gnt_tag = {1'b0, gnt_idx} + 4'd7;
    end
  end

  // A granted buffer can take a new result on the same edge it drains.
  assign src_ready = ~full_p0 | gnt;
  assign fire      = src_valid & src_ready;
  assign ls_bad    = (LS_idx[2:1] == 2'b11);

  always_comb begin
    fill = fire;
    if (ls_bad) fill[LS_SLOT] = 1'b0;
  end

  // p0: holding buffers and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_p0 <= '0;
      last_p0 <= LS_SLOT;
    end else begin
      full_p0 <= (full_p0 & ~gnt) | fill;
      if (gnt_any) last_p0 <= gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (fill[i]) buf_p0[i] <= src_data[i];
    end
    if (fill[LS_SLOT]) ls_tag_p0 <= {1'b0, LS_idx} + 4'd1;
  end

  // p1: registered broadcast bus and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      tag_p1  <= 4'd0;
      data_p1 <= '0;
      err_bad <= 1'b0;
    end else begin
      vld_p1 <= gnt_any;
      tag_p1 <= gnt_tag;
      if (gnt_any) data_p1 <= buf_p0[gnt_idx];
      if (fire[LS_SLOT] && ls_bad) err_bad <= 1'b1;
    end
  end

  assign ADD1_ready  = src_ready[0];
  assign ADD2_ready  = src_ready[1];
  assign ADD3_ready  = src_ready[2];
  assign MULT1_ready = src_ready[3];
  assign MULT2_ready = src_ready[4];
  assign LS_ready    = src_ready[5];

  assign cdb_valid   = vld_p1;
  assign cdb_tag     = tag_p1;
  assign cdb_data    = data_p1;
  assign err_bad_idx = err_bad;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter, comparing a round-robin and a
// fixed-priority instance against a slot-level behavioural model every cycle.
module tb_cdb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [5:0]  v;
  logic [31:0] d [6];
  logic [2:0]  lsidx;

  wire  [5:0]  rdy_rr, rdy_fp;
  wire         vld_rr, vld_fp, err_rr, err_fp;
  wire  [3:0]  tag_rr, tag_fp;
  wire  [31:0] dat_rr, dat_fp;

  int total = 0;
  int bad   = 0;

  // Behavioural model, index 0 = fixed priority, 1 = round robin.
  logic        mfull [2][6];
  logic [31:0] mval  [2][6];
  logic [3:0]  mtag  [2][6];
  int          mlast [2];
  logic        merr  [2];
  logic        evld  [2];
  logic [3:0]  etag  [2];
  logic [31:0] edata [2];
  logic [5:0]  rdy_s [2];

  cdb_arbiter #(.RR_EN(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .ADD1_valid(v[0]), .ADD2_valid(v[1]), .ADD3_valid(v[2]),
    .MULT1_valid(v[3]), .MULT2_valid(v[4]),
    .ADD1_result(d[0]), .ADD2_result(d[1]), .ADD3_result(d[2]),
    .MULT1_result(d[3]), .MULT2_result(d[4]),
    .ADD1_ready(rdy_rr[0]), .ADD2_ready(rdy_rr[1]), .ADD3_ready(rdy_rr[2]),
    .MULT1_ready(rdy_rr[3]), .MULT2_ready(rdy_rr[4]),
    .LS_valid(v[5]), .LS_value(d[5]), .LS_idx(lsidx), .LS_ready(rdy_rr[5]),
    .cdb_valid(vld_rr), .cdb_tag(tag_rr), .cdb_data(dat_rr), .err_bad_idx(err_rr)
  );

  cdb_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .ADD1_valid(v[0]), .ADD2_valid(v[1]), .ADD3_valid(v[2]),
    .MULT1_valid(v[3]), .MULT2_valid(v[4]),
    .ADD1_result(d[0]), .ADD2_result(d[1]), .ADD3_result(d[2]),
    .MULT1_result(d[3]), .MULT2_result(d[4]),
    .ADD1_ready(rdy_fp[0]), .ADD2_ready(rdy_fp[1]), .ADD3_ready(rdy_fp[2]),
    .MULT1_ready(rdy_fp[3]), .MULT2_ready(rdy_fp[4]),
    .LS_valid(v[5]), .LS_value(d[5]), .LS_idx(lsidx), .LS_ready(rdy_fp[5]),
    .cdb_valid(vld_fp), .cdb_tag(tag_fp), .cdb_data(dat_fp), .err_bad_idx(err_fp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 6; i++) mfull[m][i] = 1'b0;
      mlast[m] = 5;
      merr[m]  = 1'b0;
      evld[m]  = 1'b0;
      etag[m]  = 4'd0;
      edata[m] = 32'd0;
    end
  endtask

  // Which slot wins this cycle: rotating search after the last winner, or lowest slot.
  function automatic int pick(input int m);
    if (m == 1) begin
      for (int k = 1; k <= 6; k++)
        if (mfull[m][(mlast[m] + k) % 6]) return (mlast[m] + k) % 6;
    end else begin
      for (int i = 0; i < 6; i++)
        if (mfull[m][i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [5:0] exp_ready(input int m, input int g);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = !mfull[m][i] || (g == i);
    return r;
  endfunction

  task automatic model_edge(input int m, input int g);
    logic [5:0] take;
    take = v & exp_ready(m, g);
    if (g >= 0) begin
      evld[m]     = 1'b1;
      etag[m]     = mtag[m][g];
      edata[m]    = mval[m][g];
      mlast[m]    = g;
      mfull[m][g] = 1'b0;
    end else begin
      evld[m] = 1'b0;
      etag[m] = 4'd0;
    end
    for (int i = 0; i < 6; i++) begin
      if (take[i]) begin
        if (i == 5 && lsidx >= 3'd6) merr[m] = 1'b1;
        else begin
          mfull[m][i] = 1'b1;
          mval[m][i]  = d[i];
          mtag[m][i]  = (i == 5) ? ({1'b0, lsidx} + 4'd1) : 4'(7 + i);
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("cdb_valid_rr", {31'd0, vld_rr}, {31'd0, evld[1]});
    chk("cdb_tag_rr",   {28'd0, tag_rr}, {28'd0, etag[1]});
    chk("cdb_data_rr",  dat_rr, edata[1]);
    chk("err_rr",       {31'd0, err_rr}, {31'd0, merr[1]});
    chk("cdb_valid_fp", {31'd0, vld_fp}, {31'd0, evld[0]});
    chk("cdb_tag_fp",   {28'd0, tag_fp}, {28'd0, etag[0]});
    chk("cdb_data_fp",  dat_fp, edata[0]);
    chk("err_fp",       {31'd0, err_fp}, {31'd0, merr[0]});
  endtask

  // One clock cycle: readies checked before the edge, bus checked just after it.
  task automatic step();
    int g [2];
    #1;
    for (int m = 0; m < 2; m++) g[m] = pick(m);
    rdy_s[0] = rdy_fp;
    rdy_s[1] = rdy_rr;
    chk("ready_fp", {26'd0, rdy_fp}, {26'd0, exp_ready(0, g[0])});
    chk("ready_rr", {26'd0, rdy_rr}, {26'd0, exp_ready(1, g[1])});
    @(posedge clk);
    for (int m = 0; m < 2; m++) model_edge(m, g[m]);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    chk("ready_in_reset", {26'd0, rdy_rr}, 32'h3f);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst_rr", {26'd0, rdy_rr}, 32'h3f);
    chk("ready_after_rst_fp", {26'd0, rdy_fp}, 32'h3f);
  endtask

  task automatic idle_inputs();
    v     = '0;
    lsidx = 3'd0;
    for (int i = 0; i < 6; i++) d[i] = $urandom;
  endtask

  initial begin
    logic [3:0]  tag_seq [6];
    logic [31:0] m1q [$];
    logic [3:0]  bus_q [$];
    int          cnt;

    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_cdb_valid", {31'd0, vld_rr}, 32'd0);
    chk("rst_cdb_tag",   {28'd0, tag_rr}, 32'd0);
    chk("rst_cdb_data",  dat_rr, 32'd0);
    chk("rst_err",       {31'd0, err_fp}, 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Single ADD2 result reaches the bus after the second edge.
    v[1] = 1'b1;
    d[1] = 32'h0000_00AB;
    step();
    v[1] = 1'b0;
    chk("single_early", {31'd0, vld_rr}, 32'd0);
    step();
    chk("single_valid", {31'd0, vld_rr}, 32'd1);
    chk("single_tag",   {28'd0, tag_rr}, 32'd8);
    chk("single_data",  dat_rr, 32'h0000_00AB);
    step();
    chk("single_once",  {31'd0, vld_rr}, 32'd0);

    // All six sources at once drain in slot order from a fresh pointer.
    do_reset();
    v = 6'h3f;
    lsidx = 3'd2;
    for (int i = 0; i < 6; i++) d[i] = 32'h100 + i;
    step();
    idle_inputs();
    chk("contend_ready_rr", {26'd0, rdy_rr}, 32'h01);
    chk("contend_ready_fp", {26'd0, rdy_fp}, 32'h01);
    tag_seq = '{4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd3};
    for (int k = 0; k < 6; k++) begin
      step();
      chk("contend_tag_rr", {28'd0, tag_rr}, {28'd0, tag_seq[k]});
      chk("contend_tag_fp", {28'd0, tag_fp}, {28'd0, tag_seq[k]});
    end
    step();
    chk("contend_drained", {31'd0, vld_rr}, 32'd0);

    // MULT1 pushes 1,2,3 against a saturating ADD1.
    do_reset();
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      v[0] = 1'b1;
      d[0] = 32'hA000 + c;
      v[3] = (cnt < 3);
      d[3] = 32'(cnt + 1);
      step();
      if (v[3] && rdy_s[1][3]) cnt++;
      if (vld_rr) bus_q.push_back(tag_rr);
      if (vld_rr && tag_rr == 4'd10) m1q.push_back(dat_rr);
    end
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      step();
      if (vld_rr && tag_rr == 4'd10) m1q.push_back(dat_rr);
    end
    chk("bp_mult1_count", m1q.size(), 32'd3);
    for (int k = 0; k < 3 && k < m1q.size(); k++) chk("bp_mult1_value", m1q[k], 32'(k + 1));
    for (int k = 0; k < 6 && k < bus_q.size(); k++)
      chk("bp_alternate", {28'd0, bus_q[k]}, (k % 2 == 0) ? 32'd7 : 32'd10);

    // Fixed priority starves LS behind a continuous ADD1.
    do_reset();
    v[0] = 1'b1;
    v[5] = 1'b1;
    lsidx = 3'd0;
    step();
    v[5] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      d[0] = $urandom;
      step();
      chk("starve_tag_fp", {28'd0, tag_fp}, 32'd7);
      chk("starve_ls_ready", {31'd0, rdy_s[0][5]}, 32'd0);
    end
    idle_inputs();
    for (int c = 0; c < 3; c++) step();

    // Illegal LS index is swallowed and flagged until reset.
    do_reset();
    v[5] = 1'b1;
    lsidx = 3'd7;
    step();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("badidx_no_bus", {31'd0, vld_rr}, 32'd0);
      chk("badidx_err",    {31'd0, err_rr}, 32'd1);
    end
    do_reset();
    chk("badidx_cleared", {31'd0, err_rr}, 32'd0);

    // Asynchronous reset with results still pending.
    v[0] = 1'b1; v[1] = 1'b1; v[2] = 1'b1; v[3] = 1'b1;
    step();
    idle_inputs();
    step();
    chk("midrst_busy", {31'd0, vld_rr}, 32'd1);
    do_reset();
    chk("midrst_cleared", {31'd0, vld_rr}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("midrst_silent", {31'd0, vld_fp | vld_rr}, 32'd0);
    end

    // Randomized traffic with occasional bad indices and resets.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 6; i++) begin
        v[i] = ($urandom % 100) < 55;
        d[i] = $urandom;
      end
      lsidx = (($urandom % 20) == 0) ? 3'(6 + $urandom % 2) : 3'($urandom % 6);
      if (($urandom % 400) == 0) do_reset();
      else step();
    end
    idle_inputs();
    for (int c = 0; c < 10; c++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
